uart_tx_sample: RTL and testbench

Downstream UART serializer that consumes the signed 9-bit pixel samples emitted by the BRAM read-out stage. Handshake is send/busy. Each accepted sample goes out as two 8N1 frames on the board TX pin: a low byte, then a sign-extended high byte, so the host can rebuild a 16-bit signed value. The block also counts transmitted samples so software and ILA can confirm a full frame of 49284 samples.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_baud_tick.sv | 34 +++
 rtl/uart_tx_sample.sv | 125 ++++++++++++
 tb/tb_uart_tx_sample.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants, state encoding and byte mapping for the sample UART transmitter.
package uart_pkg;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;
  localparam logic [15:0] FRAME_SAMPLES        = 16'd49284;

  localparam int unsigned SAMPLE_W = 9;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned SEXT_W   = 2 * BYTE_W - SAMPLE_W;
  localparam int unsigned BAUD_W   = 16;
  localparam int unsigned COUNT_W  = 16;
  localparam int unsigned BIT_IDX_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

  // Byte 0 is the low byte; byte 1 is the sign extension of bit 8.
  function automatic logic [BYTE_W-1:0] sample_byte(input logic [SAMPLE_W-1:0] d,
                                                     input logic idx);
    if (idx) return {{SEXT_W{d[SAMPLE_W-1]}}, d[SAMPLE_W-1]};
    return d[BYTE_W-1:0];
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: bit_tick_o is high in the last cycle of each bit period.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  output logic bit_tick_o
);

  logic [BAUD_W-1:0] cnt_q, cnt_d;
  logic              tick_q;

  always_comb begin
    cnt_d = cnt_q + BAUD_W'(1);
    if (clear_i || tick_q) cnt_d = '0;
  end

  // Tick is registered alongside the count so it lines up with cnt_q == CLKS_PER_BIT-1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == BAUD_W'(CLKS_PER_BIT - 1));
    end
  end

  assign bit_tick_o = tick_q;

endmodule

// File: rtl/uart_tx_sample.sv
// Serializes signed 9-bit samples as two 8N1 frames (low byte, sign-extended high byte).
module uart_tx_sample
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                send,
  input  logic [SAMPLE_W-1:0] transmit_data,
  output logic                busy,
  output logic                tx,
  output logic                tx_done,
  output logic [COUNT_W-1:0]  sample_count
);

  state_e                state_q;
  logic [SAMPLE_W-1:0]   shadow_q;
  logic [BYTE_W-1:0]     shift_q;
  logic [BIT_IDX_W-1:0]  bit_idx_q;
  logic                  byte_idx_q;
  logic                  tx_q;
  logic                  busy_q;
  logic                  tx_done_q;
  logic [COUNT_W-1:0]    count_q;

  logic                  bit_tick;
  logic                  baud_clear_c;
  logic [BYTE_W-1:0]     cur_byte_c;

  // Hold the baud counter at zero whenever no bit is on the line.
  assign baud_clear_c = (state_q == ST_IDLE) || (state_q == ST_GAP);
  assign cur_byte_c   = sample_byte(shadow_q, byte_idx_q);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear_i    (baud_clear_c),
    .bit_tick_o (bit_tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      shadow_q   <= '0;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      tx_done_q  <= 1'b0;
      count_q    <= '0;
    end else begin
      tx_done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (send) begin
            shadow_q   <= transmit_data;
            byte_idx_q <= 1'b0;
            bit_idx_q  <= '0;
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ST_START;
          end
        end
        ST_START: begin
          if (bit_tick) begin
            shift_q   <= cur_byte_c;
            tx_q      <= cur_byte_c[0];
            bit_idx_q <= '0;
            state_q   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            if (bit_idx_q == BIT_IDX_W'(BYTE_W - 1)) begin
              tx_q      <= 1'b1;
              bit_idx_q <= '0;
              state_q   <= ST_STOP;
            end else begin
              shift_q   <= {1'b0, shift_q[BYTE_W-1:1]};
              tx_q      <= shift_q[1];
              bit_idx_q <= bit_idx_q + BIT_IDX_W'(1);
            end
          end
        end
        ST_STOP: begin
          if (bit_tick) begin
            if (bit_idx_q == BIT_IDX_W'(STOP_BITS - 1)) begin
              bit_idx_q <= '0;
              if (!byte_idx_q) begin
                // Second frame follows immediately, no idle bit in between.
                byte_idx_q <= 1'b1;
                tx_q       <= 1'b0;
                state_q    <= ST_START;
              end else begin
                tx_done_q <= 1'b1;
                busy_q    <= 1'b0;
                count_q   <= count_q + COUNT_W'(1);
                state_q   <= ST_GAP;
              end
            end else begin
              bit_idx_q <= bit_idx_q + BIT_IDX_W'(1);
            end
          end
        end
        ST_GAP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx           = tx_q;
  assign busy         = busy_q;
  assign tx_done      = tx_done_q;
  assign sample_count = count_q;

endmodule

// File: tb/tb_uart_tx_sample.sv
// Self-checking bench for uart_tx_sample: random samples against a signed 16-bit byte model.
module tb_uart_tx_sample;

  localparam int CPB      = 4;
  localparam int SAMPLE_T = 2 * 10 * CPB;
  localparam int N_BULK   = 150;

  logic        clk;
  logic        reset_n;
  logic        send;
  logic [8:0]  transmit_data;
  logic        busy;
  logic        tx;
  logic        tx_done;
  logic [15:0] sample_count;

  int checks;
  int failures;
  logic [15:0] exp_count;
  logic [7:0]  rx_q[$];
  logic [7:0]  exp_q[$];

  uart_tx_sample #(
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (1)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .send         (send),
    .transmit_data(transmit_data),
    .busy         (busy),
    .tx           (tx),
    .tx_done      (tx_done),
    .sample_count (sample_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Host-side view: the sample as a 16-bit two's complement value, split into bytes.
  function automatic void model_bytes(input logic [8:0] d, output logic [7:0] lo,
                                      output logic [7:0] hi);
    int v;
    v = int'($signed(d));
    if (v < 0) v = v + 65536;
    lo = 8'(v % 256);
    hi = 8'(v / 256);
  endfunction

  // Receiver sampling each bit near its middle.
  initial begin : uart_mon
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && tx === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        checks++;
        if (tx !== 1'b0) begin
          failures++;
          $display("FAIL mon_start_bit: got tx=%b need 0 at %0t", tx, $time);
        end
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin
          failures++;
          $display("FAIL mon_stop_bit: got tx=%b need 1 at %0t", tx, $time);
        end
        rx_q.push_back(b);
      end
    end
  end

  task automatic do_send(input logic [8:0] d);
    logic [7:0] lo, hi;
    @(negedge clk);
    send          = 1'b1;
    transmit_data = d;
    @(negedge clk);
    send = 1'b0;
    model_bytes(d, lo, hi);
    exp_q.push_back(lo);
    exp_q.push_back(hi);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    send          = 1'b0;
    transmit_data = '0;
    exp_count     = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || sample_count !== 16'd0 || tx_done !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle cyc%0d: got tx=%b busy=%b done=%b cnt=%0d need 1 0 0 0",
                 i, tx, busy, tx_done, sample_count);
      end
    end
  endtask

  task automatic test_timing();
    logic [7:0] lo, hi, bytes[2];
    logic       exp_bits[$];
    model_bytes(9'h1F5, lo, hi);
    bytes[0] = lo;
    bytes[1] = hi;
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 10; j++) begin
        logic bitv;
        bitv = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : bytes[k][j-1];
        repeat (CPB) exp_bits.push_back(bitv);
      end
    end
    do_send(9'h1F5);
    for (int i = 1; i <= SAMPLE_T; i++) begin
      checks++;
      if (tx !== exp_bits[i-1] || busy !== 1'b1 || tx_done !== 1'b0) begin
        failures++;
        $display("FAIL stream_1F5 cyc%0d: got tx=%b busy=%b done=%b need tx=%b busy=1 done=0",
                 i, tx, busy, tx_done, exp_bits[i-1]);
      end
      @(negedge clk);
    end
    exp_count = exp_count + 16'd1;
    checks++;
    if (tx_done !== 1'b1 || busy !== 1'b0 || sample_count !== exp_count) begin
      failures++;
      $display("FAIL done_cyc81: got done=%b busy=%b cnt=%0d need 1 0 %0d",
               tx_done, busy, sample_count, exp_count);
    end
    @(negedge clk);
    checks++;
    if (tx_done !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse_width: got done=%b need 0", tx_done);
    end
    checks++;
    if (rx_q.size() != 2 || exp_q.size() != 2 || rx_q[0] !== 8'hF5 || rx_q[1] !== 8'hFF) begin
      failures++;
      $display("FAIL bytes_1F5: got %0d bytes need F5 FF", rx_q.size());
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic test_sign_ext();
    bit ok;
    logic [8:0] vals[2];
    vals[0] = 9'h07A;
    vals[1] = 9'h100;
    for (int s = 0; s < 2; s++) begin
      do_send(vals[s]);
      wait_idle(4 * SAMPLE_T, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL sign_ext_timeout: got busy=%b need 0", busy);
      end
      exp_count = exp_count + 16'd1;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (rx_q.size() != 4 || rx_q[0] !== 8'h7A || rx_q[1] !== 8'h00 ||
        rx_q[2] !== 8'h00 || rx_q[3] !== 8'hFF) begin
      failures++;
      $display("FAIL sign_ext_bytes: got %0d bytes need 7A 00 00 FF", rx_q.size());
    end
    checks++;
    if (sample_count !== exp_count) begin
      failures++;
      $display("FAIL sign_ext_count: got %0d need %0d", sample_count, exp_count);
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic test_send_while_busy();
    bit ok;
    logic [8:0] d;
    d = 9'($urandom);
    do_send(d);
    repeat (9) @(negedge clk);
    send = 1'b1;
    transmit_data = ~d;
    @(negedge clk);
    send = 1'b0;
    repeat (29) @(negedge clk);
    send = 1'b1;
    transmit_data = d ^ 9'h155;
    @(negedge clk);
    send = 1'b0;
    wait_idle(4 * SAMPLE_T, ok);
    exp_count = exp_count + 16'd1;
    repeat (CPB * 30) @(negedge clk);
    checks++;
    if (!ok || sample_count !== exp_count) begin
      failures++;
      $display("FAIL busy_ignore_count: got cnt=%0d ok=%0d need %0d", sample_count, ok, exp_count);
    end
    checks++;
    if (rx_q.size() != 2 || rx_q[0] !== exp_q[0] || rx_q[1] !== exp_q[1]) begin
      failures++;
      $display("FAIL busy_ignore_bytes: got %0d bytes need 2 (%h %h)",
               rx_q.size(), exp_q[0], exp_q[1]);
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int lost;
    for (int s = 0; s < N_BULK; s++) begin
      do_send(9'($urandom));
      repeat (2) @(negedge clk);
      wait_idle(4 * SAMPLE_T, ok);
      if (!ok) lost++;
      exp_count = exp_count + 16'd1;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (lost != 0) begin
      failures++;
      $display("FAIL bulk_timeouts: got %0d need 0", lost);
    end
    checks++;
    if (sample_count !== exp_count) begin
      failures++;
      $display("FAIL bulk_count: got %0d need %0d", sample_count, exp_count);
    end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL bulk_byte_count: got %0d need %0d", rx_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (rx_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL bulk_byte%0d: got %h need %h", i, rx_q[i], exp_q[i]);
        end
      end
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    logic [8:0] d;
    do_send(9'($urandom));
    // Cycle 58 after the strobe lies inside bit 3 of the high byte.
    repeat (57) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || sample_count !== 16'd0) begin
      failures++;
      $display("FAIL async_reset: got tx=%b busy=%b cnt=%0d need 1 0 0", tx, busy, sample_count);
    end
    exp_count = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    rx_q.delete();
    exp_q.delete();
    d = 9'($urandom);
    do_send(d);
    wait_idle(4 * SAMPLE_T, ok);
    exp_count = exp_count + 16'd1;
    repeat (2) @(negedge clk);
    checks++;
    if (!ok || sample_count !== 16'd1) begin
      failures++;
      $display("FAIL post_reset_count: got %0d need 1", sample_count);
    end
    checks++;
    if (rx_q.size() != 2 || rx_q[0] !== exp_q[0] || rx_q[1] !== exp_q[1]) begin
      failures++;
      $display("FAIL post_reset_bytes: got %0d bytes need 2 (%h %h)",
               rx_q.size(), exp_q[0], exp_q[1]);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_timing();
    test_sign_ext();
    test_send_while_busy();
    test_back_to_back();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
